// File: rtl/dbg_gpr_access.sv
// Debug GPR access unit: halts the core, performs one register access, responds.
// Optional DBG_STICKY_HALT_EN keeps the halt request up between commands.
module dbg_gpr_access #(
  parameter int unsigned HALT_TIMEOUT = 256,
  parameter int unsigned TMO_W        = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [4:0]  req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        halt_req_o,
  input  logic        halted_i,
  input  logic        dbg_resume_i,
  output logic        jtag_en_o,
  output logic [4:0]  jtag_addr_o,
  output logic [31:0] jtag_data_o,
  input  logic [31:0] jtag_data_i
);

  typedef enum logic [1:0] {
    IDLE,
    HALT_WAIT,
    ACCESS,
    RESP
  } state_e;

  localparam logic [TMO_W-1:0] TMO = TMO_W'(HALT_TIMEOUT);

  state_e            state_q, state_d;
  logic              write_q, write_d;
  logic [4:0]        addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [TMO_W-1:0]  cnt_q, cnt_d;
  logic              req_fire;
  logic              in_access;

  assign req_ready_o  = (state_q == IDLE) && !rst_i;
  assign req_fire     = req_valid_i && req_ready_o;
  assign in_access    = (state_q == ACCESS);
  assign resp_valid_o = (state_q == RESP);
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;
  assign jtag_en_o    = in_access && write_q && (addr_q != 5'd0) && !rst_i;
  assign jtag_addr_o  = in_access ? addr_q : 5'd0;
  assign jtag_data_o  = (in_access && write_q) ? wdata_q : 32'd0;

  // Next-state, command latch, timeout counter and response capture
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_fire) begin
          write_d = req_write_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          state_d = HALT_WAIT;
        end
      end
      HALT_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (halted_i) begin
          state_d = ACCESS;
        end else if (cnt_d == TMO) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = 32'd0;
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (!write_q) begin
          rdata_d = (addr_q == 5'd0) ? 32'd0 : jtag_data_i;
        end
      end
      RESP: begin
        if (resp_ready_i) begin
          state_d = IDLE;
          cnt_d   = '0;
          rdata_d = 32'd0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      addr_q  <= 5'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef DBG_STICKY_HALT_EN
  logic sticky_q, sticky_d;

  assign halt_req_o = (state_q != IDLE) || sticky_q;

  // Sticky halt: set on response, cleared by resume in IDLE unless a request wins
  always_comb begin
    sticky_d = sticky_q;
    if ((state_q == RESP) && resp_ready_i) begin
      sticky_d = 1'b1;
    end
    if ((state_q == IDLE) && dbg_resume_i && !req_fire) begin
      sticky_d = 1'b0;
    end
  end

  // Sticky halt register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end
`else
  logic unused_resume;

  assign unused_resume = dbg_resume_i;
  assign halt_req_o    = (state_q != IDLE);
`endif

endmodule

// File: tb/tb_dbg_gpr_access.sv
// Directed bench for dbg_gpr_access with a small register-file model.
// Runs with or without DBG_STICKY_HALT_EN.
module tb_dbg_gpr_access;

`ifdef DBG_STICKY_HALT_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [4:0]  req_addr = 5'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        halt_req;
  logic        halted = 1'b0;
  logic        resume = 1'b0;
  logic        jtag_en;
  logic [4:0]  jtag_addr;
  logic [31:0] jtag_wdata;
  logic [31:0] jtag_rdata;

  int errors = 0;
  int checks = 0;
  int en_count = 0;
  logic [31:0] regs [32] = '{default: 32'h0};

  always #5 clk = ~clk;

  // x0 deliberately returns junk so the unit must force zero itself
  assign jtag_rdata = (jtag_addr == 5'd0) ? 32'hFFFF_FFFF : regs[jtag_addr];

  always @(posedge clk) begin
    if (jtag_en) begin
      regs[jtag_addr] <= jtag_wdata;
      en_count <= en_count + 1;
    end
  end

  dbg_gpr_access #(.HALT_TIMEOUT(8), .TMO_W(16)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_write_i(req_write),
    .req_addr_i(req_addr),
    .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid),
    .resp_ready_i(resp_ready),
    .resp_rdata_o(resp_rdata),
    .resp_err_o(resp_err),
    .halt_req_o(halt_req),
    .halted_i(halted),
    .dbg_resume_i(resume),
    .jtag_en_o(jtag_en),
    .jtag_addr_o(jtag_addr),
    .jtag_data_o(jtag_wdata),
    .jtag_data_i(jtag_rdata)
  );

  task automatic send(input logic w, input logic [4:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready_in_rst got=%b exp=0", req_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, resp_err, halt_req, jtag_en} !== 5'b10000 ||
        jtag_addr !== 5'd0 || jtag_wdata !== 32'd0 || resp_rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%b%b%b%b%b addr=%h d=%h r=%h exp=10000/0/0/0",
               req_ready, resp_valid, resp_err, halt_req, jtag_en,
               jtag_addr, jtag_wdata, resp_rdata);
    end
  endtask

  task automatic test_write();
    halted = 1'b1;
    send(1'b1, 5'd5, 32'hDEAD_BEEF);
    @(negedge clk);
    checks++;
    if ({resp_valid, halt_req, req_ready, jtag_en} !== 4'b0100) begin
      errors++;
      $display("FAIL write_halt_wait got=%b%b%b%b exp=0100",
               resp_valid, halt_req, req_ready, jtag_en);
    end
    @(negedge clk);
    checks++;
    if (jtag_en !== 1'b1 || jtag_addr !== 5'd5 || jtag_wdata !== 32'hDEAD_BEEF ||
        resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL write_access got=en%b a%h d%h v%b exp=en1 a05 dDEADBEEF v0",
               jtag_en, jtag_addr, jtag_wdata, resp_valid);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b0 || jtag_en !== 1'b0 ||
        resp_rdata !== 32'd0 || halt_req !== 1'b1) begin
      errors++;
      $display("FAIL write_resp got=v%b e%b en%b r%h h%b exp=v1 e0 en0 r0 h1",
               resp_valid, resp_err, jtag_en, resp_rdata, halt_req);
    end
    checks++;
    if (en_count !== 1 || regs[5] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL write_once got=cnt%0d x5=%h exp=cnt1 x5=DEADBEEF",
               en_count, regs[5]);
    end
    finish_resp();
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || halt_req !== STICKY) begin
      errors++;
      $display("FAIL write_idle got=v%b rdy%b h%b exp=v0 rdy1 h%b",
               resp_valid, req_ready, halt_req, STICKY);
    end
  endtask

  task automatic test_read();
    int n;
    halted = 1'b1;
    send(1'b0, 5'd5, 32'd0);
    n = 0;
    do begin @(negedge clk); n++; end while (!resp_valid && n < 50);
    checks++;
    if (n !== 3 || resp_rdata !== 32'hDEAD_BEEF || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL read_x5 got=lat%0d r%h e%b exp=lat3 rDEADBEEF e0",
               n, resp_rdata, resp_err);
    end
    finish_resp();
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL back_to_back_ready got=%b exp=1", req_ready);
    end
    send(1'b0, 5'd0, 32'd0);
    n = 0;
    do begin @(negedge clk); n++; end while (!resp_valid && n < 50);
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'd0 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL read_x0 got=v%b r%h e%b exp=v1 r0 e0",
               resp_valid, resp_rdata, resp_err);
    end
    finish_resp();
    send(1'b1, 5'd0, 32'h1234_5678);
    n = 0;
    do begin @(negedge clk); n++; end while (!resp_valid && n < 50);
    checks++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b0 || en_count !== 1) begin
      errors++;
      $display("FAIL write_x0 got=v%b e%b cnt%0d exp=v1 e0 cnt1",
               resp_valid, resp_err, en_count);
    end
    finish_resp();
  endtask

  task automatic test_timeout();
    int n;
    halted = 1'b0;
    send(1'b1, 5'd3, 32'h0000_1234);
    n = 0;
    do begin @(negedge clk); n++; end while (!resp_valid && n < 50);
    checks++;
    if (n !== 9 || resp_err !== 1'b1 || resp_rdata !== 32'd0 || halt_req !== 1'b1) begin
      errors++;
      $display("FAIL timeout_resp got=lat%0d e%b r%h h%b exp=lat9 e1 r0 h1",
               n, resp_err, resp_rdata, halt_req);
    end
    checks++;
    if (en_count !== 1 || regs[3] !== 32'd0) begin
      errors++;
      $display("FAIL timeout_no_write got=cnt%0d x3=%h exp=cnt1 x3=0", en_count, regs[3]);
    end
    finish_resp();
    @(negedge clk);
    checks++;
    if (halt_req !== STICKY || resp_err !== 1'b0 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_idle got=h%b e%b v%b exp=h%b e0 v0",
               halt_req, resp_err, resp_valid, STICKY);
    end
  endtask

  task automatic test_stall();
    int n;
    halted = 1'b0;
    send(1'b0, 5'd5, 32'd0);
    repeat (5) @(posedge clk);
    #1 halted = 1'b1;
    n = 0;
    while (!resp_valid && n < 50) begin
      @(negedge clk); n++;
      checks++;
      if (req_ready !== 1'b0) begin
        errors++; $display("FAIL stall_ready_wait got=%b exp=0", req_ready);
      end
    end
    checks++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL stall_resp got=v%b e%b exp=v1 e0", resp_valid, resp_err);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEAD_BEEF || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d got=v%b r%h rdy%b exp=v1 rDEADBEEF rdy0",
                 i, resp_valid, resp_rdata, req_ready);
      end
    end
    finish_resp();
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== 32'd0) begin
      errors++;
      $display("FAIL stall_idle got=v%b rdy%b r%h exp=v0 rdy1 r0",
               resp_valid, req_ready, resp_rdata);
    end
  endtask

  task automatic test_reset_abort();
    halted = 1'b0;
    send(1'b1, 5'd7, 32'hA5A5_A5A5);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    halted = 1'b1;
    @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, resp_err, halt_req, jtag_en} !== 5'b10000 ||
        jtag_addr !== 5'd0 || resp_rdata !== 32'd0) begin
      errors++;
      $display("FAIL abort_outputs got=%b%b%b%b%b a%h r%h exp=10000 a0 r0",
               req_ready, resp_valid, resp_err, halt_req, jtag_en, jtag_addr, resp_rdata);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || jtag_en !== 1'b0) begin
        checks++; errors++;
        $display("FAIL abort_no_resp cycle%0d got=v%b en%b exp=v0 en0", i, resp_valid, jtag_en);
      end
    end
    checks++;
    if (en_count !== 1 || regs[7] !== 32'd0) begin
      errors++;
      $display("FAIL abort_no_write got=cnt%0d x7=%h exp=cnt1 x7=0", en_count, regs[7]);
    end
  endtask

  task automatic test_sticky();
    int n;
    halted = 1'b1;
    send(1'b0, 5'd5, 32'd0);
    n = 0;
    do begin @(negedge clk); n++; end while (!resp_valid && n < 50);
    finish_resp();
    @(negedge clk);
    checks++;
    if (halt_req !== STICKY) begin
      errors++; $display("FAIL sticky_after_read1 got=%b exp=%b", halt_req, STICKY);
    end
    send(1'b0, 5'd5, 32'd0);
    n = 0;
    do begin @(negedge clk); n++; end while (!resp_valid && n < 50);
    checks++;
    if (n !== 3 || resp_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL sticky_read2 got=lat%0d r%h exp=lat3 rDEADBEEF", n, resp_rdata);
    end
    finish_resp();
    #1 resume = 1'b1;
    @(negedge clk);
    checks++;
    if (halt_req !== STICKY) begin
      errors++; $display("FAIL sticky_resume_same got=%b exp=%b", halt_req, STICKY);
    end
    @(posedge clk); #1;
    resume = 1'b0;
    @(negedge clk);
    checks++;
    if (halt_req !== 1'b0) begin
      errors++; $display("FAIL sticky_resume_clear got=%b exp=0", halt_req);
    end
    send(1'b0, 5'd5, 32'd0);
    n = 0;
    do begin @(negedge clk); n++; end while (!resp_valid && n < 50);
    finish_resp();
    @(posedge clk); #1;
    req_write = 1'b0; req_addr = 5'd5; req_valid = 1'b1; resume = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; resume = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!resp_valid && n < 50);
    checks++;
    if (resp_valid !== 1'b1 || halt_req !== 1'b1) begin
      errors++;
      $display("FAIL coincident_resp got=v%b h%b exp=v1 h1", resp_valid, halt_req);
    end
    finish_resp();
    @(negedge clk);
    checks++;
    if (halt_req !== STICKY) begin
      errors++; $display("FAIL coincident_halt got=%b exp=%b", halt_req, STICKY);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_stall();
    test_reset_abort();
    test_sticky();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
